// File: rtl/tune_pkg.sv
// Shared types and tune tables for the tune sequencer.
// Each entry is a tone half-period in clocks (0 = rest) and a beat count (0 = end).
package tune_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [14:0] half_period;
    logic [3:0]  beats;
  } entry_t;

  // Half-periods assume a 25 MHz clock; every entry has non-zero beats.
  function automatic entry_t melody(input logic [3:0] idx);
    entry_t e;
    case (idx)
      4'd0:    e = '{15'd23900, 4'd1};
      4'd1:    e = '{15'd21294, 4'd1};
      4'd2:    e = '{15'd18968, 4'd1};
      4'd3:    e = '{15'd23900, 4'd1};
      4'd4:    e = '{15'd18968, 4'd2};
      4'd5:    e = '{15'd15944, 4'd2};
      4'd6:    e = '{15'd11945, 4'd4};
      4'd7:    e = '{15'd15944, 4'd1};
      4'd8:    e = '{15'd14205, 4'd1};
      4'd9:    e = '{15'd15944, 4'd1};
      4'd10:   e = '{15'd17908, 4'd1};
      4'd11:   e = '{15'd18968, 4'd2};
      4'd12:   e = '{15'd21294, 4'd2};
      4'd13:   e = '{15'd18968, 4'd2};
      4'd14:   e = '{15'd21294, 4'd4};
      default: e = '{15'd23900, 4'd4};
    endcase
    return e;
  endfunction

  function automatic entry_t test_tune(input logic [3:0] idx);
    entry_t e;
    case (idx)
      4'd0:    e = '{15'd4, 4'd2};
      4'd1:    e = '{15'd0, 4'd1};
      4'd2:    e = '{15'd6, 4'd1};
      default: e = '{15'd0, 4'd0};
    endcase
    return e;
  endfunction

  function automatic entry_t tune_entry(input int sel,
                                        input logic [3:0] idx);
    return (sel == 1) ? test_tune(idx) : melody(idx);
  endfunction

endpackage

// File: rtl/tune_sequencer_tone_gen.sv
// Square-wave tone divider: toggles every half_period clocks while enabled,
// first toggle half_period clocks after enable rises; silent otherwise.
module tone_gen
  import tune_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [14:0] half_period,
  output logic        speaker
);

  logic [14:0] div_q, div_d;
  logic        run_q, run_d;
  logic        spk_q, spk_d;

  always_comb begin
    div_d = '0;
    run_d = 1'b0;
    spk_d = 1'b0;
    if (en && half_period != 15'd0) begin
      run_d = 1'b1;
      spk_d = spk_q;
      if (!run_q) begin
        // first enabled cycle already counts toward the first half-period
        if (half_period == 15'd1) begin
          spk_d = ~spk_q;
          div_d = 15'd0;
        end else begin
          div_d = half_period - 15'd2;
        end
      end else if (div_q == 15'd0) begin
        spk_d = ~spk_q;
        div_d = half_period - 15'd1;
      end else begin
        div_d = div_q - 15'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      run_q <= 1'b0;
      spk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      run_q <= run_d;
      spk_q <= spk_d;
    end
  end

  assign speaker = spk_q & en;

endmodule

// File: rtl/tune_sequencer.sv
// Tune sequencer: steps through a 16-entry tune table, playing each note for
// beats*BEAT_CYCLES clocks followed by GAP_CYCLES of silence.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 250000,
  parameter int TUNE_SEL    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       speaker,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int MAXC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PW-1:0] BEAT_LD = PW'(BEAT_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LD  = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] ONE     = PW'(1);

  if (CLK_HZ < 1 || BEAT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
    $error("tune_sequencer: CLK_HZ, BEAT_CYCLES, GAP_CYCLES must be >= 1");
  end

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [14:0] hp_q, hp_d;
  logic [3:0]  beats_q, beats_d;
  logic [PW-1:0] presc_q, presc_d;
  entry_t      ent;

  assign ent = tune_entry(TUNE_SEL, idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hp_d    = hp_q;
    beats_d = beats_q;
    presc_d = presc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          idx_d   = 4'd0;
        end
      end
      S_LOAD: begin
        hp_d = ent.half_period;
        if (ent.beats == 4'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PLAY;
          beats_d = ent.beats;
          presc_d = BEAT_LD;
        end
      end
      S_PLAY: begin
        if (presc_q != '0) begin
          presc_d = presc_q - ONE;
        end else if (beats_q > 4'd1) begin
          beats_d = beats_q - 4'd1;
          presc_d = BEAT_LD;
        end else begin
          beats_d = 4'd0;
          presc_d = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (presc_q != '0) begin
          presc_d = presc_q - ONE;
        end else if (idx_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (loop) begin
          state_d = S_LOAD;
          idx_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort keeps note_idx so software can see where playback stopped
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      beats_d = 4'd0;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hp_q    <= '0;
      beats_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hp_q    <= hp_d;
      beats_q <= beats_d;
      presc_q <= presc_d;
    end
  end

  tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state_q == S_PLAY),
    .half_period (hp_q),
    .speaker     (speaker)
  );

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer: test tune timing, loop, stop, reset,
// and full 16-note default melody length.
module tb_tune_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop;
  logic       speaker, busy, done;
  logic [3:0] note_idx;
  logic       m_start, m_stop, m_loop;
  logic       m_speaker, m_busy, m_done;
  logic [3:0] m_note_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tune_sequencer #(
    .CLK_HZ(25000000), .BEAT_CYCLES(10), .GAP_CYCLES(2), .TUNE_SEL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .speaker(speaker), .busy(busy), .note_idx(note_idx), .done(done)
  );

  tune_sequencer #(
    .CLK_HZ(25000000), .BEAT_CYCLES(10), .GAP_CYCLES(2), .TUNE_SEL(0)
  ) u_mel (
    .clk(clk), .rst_n(rst_n), .start(m_start), .stop(m_stop), .loop(m_loop),
    .speaker(m_speaker), .busy(m_busy), .note_idx(m_note_idx), .done(m_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Test tune, offset d from LOAD of note 0:
  // LOAD 0, PLAY 1..20 (hp 4), GAP 21-22, LOAD 23, rest 24..33, GAP 34-35,
  // LOAD 36, PLAY 37..46 (hp 6), GAP 47-48, LOAD 49, DONE 50.
  function automatic logic exp_spk(input int d);
    if (d >= 1 && d <= 20) return logic'(((d - 1) / 4) % 2);
    if (d >= 37 && d <= 46) return logic'(((d - 37) / 6) % 2);
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_idx(input int d);
    if (d <= 22) return 4'd0;
    if (d <= 35) return 4'd1;
    if (d <= 48) return 4'd2;
    return 4'd3;
  endfunction

  task automatic run_tune(input int passes, input bit repulse);
    int last;
    int d;
    last = 51 * passes - 1;
    loop = (passes > 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load0_busy", busy, 1);
    chk("load0_idx", note_idx, 0);
    for (int off = 1; off <= last; off++) begin
      tick();
      d = off % 51;
      chk($sformatf("spk@%0d", off), speaker, exp_spk(d));
      chk($sformatf("done@%0d", off), done, (d == 50));
      chk($sformatf("busy@%0d", off), busy, 1);
      chk($sformatf("idx@%0d", off), note_idx, exp_idx(d));
      start = repulse && (off == 5);
      if (off == 51 * (passes - 1) + 10) loop = 1'b0;
    end
    tick();
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_spk", speaker, 0);
    chk("end_idx", note_idx, 3);
  endtask

  initial begin
    int nd;
    int nb;
    int n;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    m_start = 1'b0; m_stop = 1'b0; m_loop = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spk", speaker, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_mbusy", m_busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // single pass, then two looped passes
    run_tune(1, 1'b0);
    run_tune(2, 1'b0);

    // stop on PLAY cycle 7 of note 0
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_stop_spk", speaker, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_spk", speaker, 0);
    chk("stop_done", done, 0);
    chk("stop_idx", note_idx, 0);
    nd = 0;
    nb = 0;
    repeat (60) begin
      tick();
      if (done) nd++;
      if (busy || speaker) nb++;
    end
    chk("stop_no_done", nd, 0);
    chk("stop_stays_idle", nb, 0);
    chk("stop_idx_held", note_idx, 0);

    // start and stop together, then start re-pulsed during PLAY
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", busy, 0);
    tick();
    chk("startstop_busy2", busy, 0);
    run_tune(1, 1'b1);

    // async reset in GAP of note 1
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34) tick();
    chk("gap1_busy", busy, 1);
    chk("gap1_idx", note_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_spk", speaker, 0);
    chk("arst_idx", note_idx, 0);
    chk("arst_done", done, 0);
    tick();
    rst_n = 1'b1;
    nb = 0;
    repeat (20) begin
      tick();
      if (busy || speaker || done) nb++;
    end
    chk("post_rst_idle", nb, 0);
    run_tune(1, 1'b0);

    // default melody: 16 notes, 30 beats -> DONE 16*3+300 cycles after LOAD
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    n = 0;
    while (!m_done && n < 1000) begin
      tick();
      n++;
    end
    chk("mel_len", n, 348);
    chk("mel_done_idx", m_note_idx, 15);
    tick();
    chk("mel_end_busy", m_busy, 0);
    chk("mel_end_idx", m_note_idx, 15);
    chk("mel_end_spk", m_speaker, 0);
    m_loop = 1'b1;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    n = 0;
    while (!m_done && n < 1000) begin
      tick();
      n++;
    end
    chk("mel_loop_len", n, 348);
    tick();
    chk("mel_wrap_busy", m_busy, 1);
    chk("mel_wrap_idx", m_note_idx, 0);
    m_stop = 1'b1;
    tick();
    m_stop = 1'b0;
    m_loop = 1'b0;
    chk("mel_stop_busy", m_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tune_sequencer.md
TUNE_SEQUENCER -- requirements
Module: tune_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 25000000: system clock frequency in Hz, informational only.
REQ-002 Parameter BEAT_CYCLES, default 6250000: clock cycles per beat (250 ms).
REQ-003 Parameter GAP_CYCLES, default 250000: silent cycles inserted after every note (10 ms).
REQ-004 Parameter TUNE_SEL, default 0: selects the tune table; 0 = default melody, 1 = short test tune.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port start, input, 1 bit: request playback from note 0; sampled only in IDLE.
REQ-008 Port stop, input, 1 bit: abort playback; honoured in any state.
REQ-009 Port loop, input, 1 bit: at end of tune, restart from note 0 instead of returning to IDLE.
REQ-010 Port speaker, output, 1 bit: square-wave audio output.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port note_idx, output, 4 bits: index of the current tune entry.
REQ-013 Port done, output, 1 bit: one-cycle pulse at natural end of tune.

Function
REQ-014 The tune table SHALL hold 16 entries; each entry is a 15-bit half_period in clocks (0 = rest) and a 4-bit beats value (0 = end-of-tune marker).
REQ-015 The FSM SHALL have states IDLE, LOAD, PLAY, GAP, DONE.
REQ-016 IDLE: on start=1 and stop=0, the FSM SHALL clear note_idx to 0 and enter LOAD next cycle; stop=1 in the same cycle wins and the FSM stays in IDLE.
REQ-017 LOAD (1 cycle): the FSM SHALL latch entry[note_idx]; if beats==0 it enters DONE, otherwise it enters PLAY.
REQ-018 PLAY SHALL last exactly beats*BEAT_CYCLES cycles, counted by a beat prescaler and a beats-remaining counter, then enter GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles; if note_idx==15 it then enters DONE, otherwise it increments note_idx and enters LOAD.
REQ-020 DONE (1 cycle) SHALL assert done; the next state is LOAD with note_idx=0 if loop=1, otherwise IDLE.
REQ-021 During PLAY with half_period!=0, the tone divider SHALL reload with half_period-1 on reaching 0 and toggle speaker on each reload; the first toggle occurs half_period cycles after PLAY entry.
REQ-022 Outside PLAY, or in PLAY with half_period==0, speaker SHALL be 0 and the divider SHALL be held at 0.
REQ-023 stop=1 in any non-IDLE state SHALL force IDLE next cycle, with speaker=0 and no done pulse.
REQ-024 start while busy SHALL be ignored.
REQ-025 The divider SHALL be 15 bits wide and the prescaler SHALL be ceil(log2(max(BEAT_CYCLES,GAP_CYCLES))) bits wide; no counter may wrap silently.

Reset
REQ-026 While rst_n=0: state=IDLE, speaker=0, busy=0, done=0, note_idx=0, and all counters=0.
REQ-027 Reset asserted mid-tune SHALL take effect immediately (asynchronously); after release the block waits for a new start.

Structure
REQ-028 Package tune_pkg SHALL hold the FSM state enum, the tune entry struct (half_period, beats), the default melody table, and the test tune table.
REQ-029 Sub-module tone_gen (inputs clk, rst_n, en, half_period; output speaker) SHALL implement REQ-021/REQ-022; the FSM, prescaler, and table lookup stay in tune_sequencer.

Verification (BEAT_CYCLES=10, GAP_CYCLES=2, TUNE_SEL=1; test tune = (4,2), (0,1), (6,1), (x,0))
REQ-030 Reset, then pulse start -> busy rises next cycle; PLAY lasts 20 cycles with 5 speaker toggles spaced 4 cycles apart; rest note gives 10 cycles of speaker=0; done pulses once 1+20+2+1+10+2+1+10+2+1 cycles after LOAD entry; then busy=0.
REQ-031 loop=1 through end of tune -> DONE is followed by LOAD with note_idx=0 and busy stays high; done pulses once per pass.
REQ-032 stop asserted on cycle 7 of note 0 -> IDLE next cycle, speaker=0, done never pulses, note_idx held until the next start.
REQ-033 start and stop high together in IDLE -> stays IDLE; start re-pulsed during PLAY -> timing is identical to REQ-030.
REQ-034 rst_n low mid-GAP -> all outputs are 0 asynchronously; after release, outputs stay idle until start.
REQ-035 TUNE_SEL=0 with 16 non-zero entries -> after note_idx=15 and its GAP, the FSM enters DONE with no wrap to 0 unless loop=1.
